// File: rtl/sobel_stream_nb.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers.
// Emits one saturated |gx|+|gy| magnitude (or thresholded binary edge) per accepted pixel.
`timescale 1ns/1ps
module sobel_stream_nb #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [PIX_W-1:0]   in_pix,
    input  logic               mode,
    input  logic [PIX_W+2:0]   thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_border,
    output logic               out_sof
);

    localparam int unsigned SW      = PIX_W + 3;
    localparam int unsigned CW      = $clog2(IMG_W);
    localparam int unsigned RW      = $clog2(IMG_H);
    localparam int unsigned MAX_OUT = (2 ** OUT_W) - 1;

    logic                  en;
    logic                  accept;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         pos_col;
    logic [RW-1:0]         pos_row;
    logic [CW-1:0]         nxt_col;
    logic [RW-1:0]         nxt_row;

    logic [PIX_W-1:0]      lb_mid [IMG_W];
    logic [PIX_W-1:0]      lb_top [IMG_W];
    logic [PIX_W-1:0]      win    [9];

    logic                  s1_valid;
    logic                  s1_border;
    logic                  s1_sof;

    logic signed [SW-1:0]  ext    [9];
    logic signed [SW-1:0]  gx_c;
    logic signed [SW-1:0]  gy_c;
    logic signed [SW-1:0]  gx_q;
    logic signed [SW-1:0]  gy_q;
    logic                  s2_valid;
    logic                  s2_border;
    logic                  s2_sof;

    logic [SW-1:0]         abs_x;
    logic [SW-1:0]         abs_y;
    logic [SW-1:0]         mag_c;
    logic [OUT_W-1:0]      res_c;

    // Global stall: everything moves only when the output register can take a new value
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
        accept   = in_valid && en;
    end

    // Position of the incoming pixel (in_sof resyncs to origin) and the position after it
    always_comb begin
        pos_col = in_sof ? '0 : col_q;
        pos_row = in_sof ? '0 : row_q;
        nxt_col = pos_col + CW'(1);
        nxt_row = pos_row;
        if (pos_col == CW'(IMG_W - 1)) begin
            nxt_col = '0;
            if (pos_row == RW'(IMG_H - 1)) begin
                nxt_row = '0;
            end else begin
                nxt_row = pos_row + RW'(1);
            end
        end
    end

    // Raster position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            col_q <= nxt_col;
            row_q <= nxt_row;
        end
    end

    // Line buffers and 3x3 window shift (not reset; border masking hides stale data)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[pos_col] <= lb_mid[pos_col];
            lb_mid[pos_col] <= in_pix;
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb_top[pos_col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb_mid[pos_col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pix;
        end
    end

    // Stage 1 control: valid, border flag and sof travel alongside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            s1_sof    <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_border <= (pos_row < RW'(2)) || (pos_col < CW'(2));
            s1_sof    <= in_sof;
        end
    end

    // Signed gradients over the window; SW bits cannot overflow
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            ext[i] = $signed(SW'(win[i]));
        end
        gx_c = (ext[2] - ext[0]) + ((ext[5] - ext[3]) <<< 1) + (ext[8] - ext[6]);
        gy_c = (ext[0] - ext[6]) + ((ext[1] - ext[7]) <<< 1) + (ext[2] - ext[8]);
    end

    // Stage 2 gradient registers
    always_ff @(posedge clk) begin
        if (en) begin
            gx_q <= gx_c;
            gy_q <= gy_c;
        end
    end

    // Stage 2 control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_border <= 1'b0;
            s2_sof    <= 1'b0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_border <= s1_border;
            s2_sof    <= s1_sof;
        end
    end

    // Magnitude, then saturate or threshold; border positions forced to zero
    always_comb begin
        abs_x = gx_q[SW-1] ? SW'(-gx_q) : SW'(gx_q);
        abs_y = gy_q[SW-1] ? SW'(-gy_q) : SW'(gy_q);
        mag_c = abs_x + abs_y;
        res_c = '0;
        if (!s2_border) begin
            if (mode) begin
                res_c = (mag_c > thresh) ? '1 : '0;
            end else if (32'(mag_c) > MAX_OUT) begin
                res_c = '1;
            end else begin
                res_c = OUT_W'(mag_c);
            end
        end
    end

    // Output register, held while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_border <= 1'b0;
            out_sof    <= 1'b0;
        end else if (en) begin
            out_valid  <= s2_valid;
            out_data   <= res_c;
            out_border <= s2_border;
            out_sof    <= s2_sof;
        end
    end

endmodule
